// File: rtl/clock_pll_pkg.sv
// Shared types and defaults for the PLL reset supervisor.
package clock_pll_pkg;

  localparam int unsigned PulseCyclesDefault  = 16;
  localparam int unsigned LockTimeoutDefault  = 50000;
  localparam int unsigned StableCyclesDefault = 1024;
  localparam int unsigned MaxRetriesDefault   = 4;

  // Width of the saturating restart counter.
  localparam int unsigned RetryCntW = 8;

  typedef enum logic [2:0] {
    StPllReset = 3'd0,
    StWaitLock = 3'd1,
    StStable   = 3'd2,
    StRun      = 3'd3,
    StFailed   = 3'd4
  } state_e;

  function automatic int unsigned max3(int unsigned a, int unsigned b, int unsigned c);
    int unsigned m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

endpackage

// File: rtl/clock_pll_sync.sv
// Two-flop synchroniser for the asynchronous PLL lock indication.
module clock_pll_sync (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic meta_q;

  // Two-stage capture; both stages clear on reset so lock is never assumed.
  always_ff @(posedge clk) begin
    if (rst) begin
      meta_q <= 1'b0;
      q      <= 1'b0;
    end else begin
      meta_q <= d;
      q      <= meta_q;
    end
  end

endmodule

// File: rtl/clock_pll_supervisor.sv
// PLL reset sequencer: pulses the PLL reset, waits for a stable lock, then
// releases the downstream reset. Restarts on timeout, chatter or lock loss.
// Define CLOCK_PLL_SUP_FAIL_LATCH_EN to give up (sticky failed) once
// MAX_RETRIES restarts have been counted; otherwise retries are unlimited.
module clock_pll_supervisor
  import clock_pll_pkg::*;
#(
  parameter int unsigned PULSE_CYCLES  = PulseCyclesDefault,
  parameter int unsigned LOCK_TIMEOUT  = LockTimeoutDefault,
  parameter int unsigned STABLE_CYCLES = StableCyclesDefault,
  parameter int unsigned MAX_RETRIES   = MaxRetriesDefault
) (
  input  logic                 refclk,
  input  logic                 rst,
  input  logic                 pll_locked,
  output logic                 pll_rst,
  output logic                 sys_rst,
  output logic                 lock_lost,
  output logic [RetryCntW-1:0] retry_cnt,
  output logic                 failed
);

  localparam int unsigned TimerMax = max3(PULSE_CYCLES, LOCK_TIMEOUT, STABLE_CYCLES);
  localparam int unsigned TimerW   = $clog2(TimerMax + 1);

  // Timer values on the last cycle of each timed state.
  localparam logic [TimerW-1:0] PulseLast  = TimerW'(PULSE_CYCLES - 1);
  localparam logic [TimerW-1:0] LockLast   = TimerW'(LOCK_TIMEOUT - 1);
  localparam logic [TimerW-1:0] StableLast = TimerW'(STABLE_CYCLES - 1);

  logic                 lk;
  state_e               state_q, state_d;
  logic [TimerW-1:0]    timer_q, timer_d;
  logic [RetryCntW-1:0] retry_q, retry_d;
  logic                 retry_evt;
  logic                 pll_rst_d, sys_rst_d, lock_lost_d;

  clock_pll_sync u_sync (
    .clk (refclk),
    .rst (rst),
    .d   (pll_locked),
    .q   (lk)
  );

  // State register together with the shared timer and restart counter.
  always_ff @(posedge refclk) begin
    if (rst) begin
      state_q <= StPllReset;
      timer_q <= '0;
      retry_q <= '0;
    end else begin
      state_q <= state_d;
      timer_q <= timer_d;
      retry_q <= retry_d;
    end
  end

  // Next-state: sequencing rules, restart accounting and timer update.
  always_comb begin
    state_d   = state_q;
    retry_evt = 1'b0;
    unique case (state_q)
      StPllReset: if (timer_q == PulseLast) state_d = StWaitLock;
      // Lock wins over a timeout expiring on the same cycle.
      StWaitLock: begin
        if (lk)                        state_d   = StStable;
        else if (timer_q == LockLast)  retry_evt = 1'b1;
      end
      StStable: begin
        if (!lk)                        retry_evt = 1'b1;
        else if (timer_q == StableLast) state_d   = StRun;
      end
      StRun:    if (!lk) retry_evt = 1'b1;
      StFailed: state_d = StFailed;
      default:  state_d = StPllReset;
    endcase

    retry_d = retry_q;
    if (retry_evt) begin
      if (retry_q != '1) retry_d = retry_q + 1'b1;
      state_d = StPllReset;
`ifdef CLOCK_PLL_SUP_FAIL_LATCH_EN
      if ((int unsigned'(retry_q) + 1) == MAX_RETRIES) state_d = StFailed;
`endif
    end

    if (state_d != state_q) begin
      timer_d = '0;
    end else if (state_q inside {StPllReset, StWaitLock, StStable}) begin
      timer_d = timer_q + 1'b1;
    end else begin
      timer_d = '0;
    end
  end

  // Output decode from the upcoming state so registered outputs align with it.
  always_comb begin
    pll_rst_d   = (state_d == StPllReset) || (state_d == StFailed);
    sys_rst_d   = (state_d != StRun);
    lock_lost_d = (state_q == StRun) && !lk;
  end

  // Output registers.
  always_ff @(posedge refclk) begin
    if (rst) begin
      pll_rst   <= 1'b1;
      sys_rst   <= 1'b1;
      lock_lost <= 1'b0;
    end else begin
      pll_rst   <= pll_rst_d;
      sys_rst   <= sys_rst_d;
      lock_lost <= lock_lost_d;
    end
  end

  assign retry_cnt = retry_q;

`ifdef CLOCK_PLL_SUP_FAIL_LATCH_EN
  // Sticky give-up flag, cleared only by reset.
  always_ff @(posedge refclk) begin
    if (rst) failed <= 1'b0;
    else     failed <= (state_d == StFailed);
  end
`else
  assign failed = 1'b0;
`endif

endmodule
